axi_burst_scheduler: RTL and testbench

//  Splits one byte-granular transfer request (start address + byte count) into a sequence
//  of AXI-style INCR burst commands for the write/read datapath.

---
 rtl/axi_burst_scheduler_if.sv | 31 +++
 rtl/axi_burst_scheduler.sv | 140 ++++++++++++++
 tb/tb_axi_burst_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/axi_burst_scheduler_if.sv
// Request and burst-command bundle between the descriptor front-end,
// the burst scheduler and the AW/AR + strobe datapath.
interface axi_burst_scheduler_if #(
    parameter int DATA_BYTES = 8,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 13
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic [LEN_W-1:0]      req_bytes;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [7:0]            cmd_len;
    logic [DATA_BYTES-1:0] cmd_first_strb;
    logic [DATA_BYTES-1:0] cmd_last_strb;
    logic                  cmd_last;

    modport master (
        output req_valid, req_addr, req_bytes, cmd_ready,
        input  req_ready, cmd_valid, cmd_addr, cmd_len,
        input  cmd_first_strb, cmd_last_strb, cmd_last
    );

    modport slave (
        input  req_valid, req_addr, req_bytes, cmd_ready,
        output req_ready, cmd_valid, cmd_addr, cmd_len,
        output cmd_first_strb, cmd_last_strb, cmd_last
    );
endinterface

// File: rtl/axi_burst_scheduler.sv
// Splits a byte-granular transfer into INCR bursts that respect the
// 4 KB boundary and MAX_BEATS, with first/last beat strobes.
module axi_burst_scheduler #(
    parameter int DATA_BYTES = 8,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 13,
    parameter int MAX_BEATS  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_burst_scheduler_if.slave bus,
    output logic                 busy,
    output logic                 done
);
    localparam int OW = $clog2(DATA_BYTES);
    localparam int CW = ((LEN_W > 15) ? LEN_W : 15) + 1;
    localparam logic [DATA_BYTES-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        FINISH
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]     addr_q;
    logic [LEN_W-1:0]      rem_q;
    logic [CW-1:0]         bb_q;
    logic [ADDR_W-1:0]     cmd_addr_q;
    logic [7:0]            cmd_len_q;
    logic [DATA_BYTES-1:0] first_q;
    logic [DATA_BYTES-1:0] last_strb_q;
    logic                  last_q;

    logic [OW-1:0]         off;
    logic [OW-1:0]         end_idx;
    logic [OW-1:0]         sh;
    logic [CW-1:0]         b4k;
    logic [CW-1:0]         bmax;
    logic [CW-1:0]         bb;
    logic [CW-1:0]         span;
    logic [CW-1:0]         beats;
    logic [DATA_BYTES-1:0] fs;
    logic [DATA_BYTES-1:0] ls;
    logic [DATA_BYTES-1:0] both;
    logic [7:0]            len_w;
    logic                  last_w;

    logic accept;
    logic hs;

    assign accept = (state == IDLE) && bus.req_valid;
    assign hs     = (state == ISSUE) && bus.cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (bus.req_bytes == '0) ? FINISH : CALC;
            end
            CALC:   state_nxt = ISSUE;
            ISSUE: begin
                if (hs) state_nxt = last_q ? FINISH : CALC;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst size is the tightest of: bytes left, 4 KB page, beat limit.
    always_comb begin
        off  = addr_q[OW-1:0];
        b4k  = CW'(13'h1000 - {1'b0, addr_q[11:0]});
        bmax = CW'(MAX_BEATS * DATA_BYTES) - CW'(off);
        bb   = CW'(rem_q);
        if (b4k < bb)  bb = b4k;
        if (bmax < bb) bb = bmax;
        span    = CW'(off) + bb;
        beats   = (span + CW'(DATA_BYTES - 1)) >> OW;
        end_idx = span[OW-1:0] - OW'(1);
        sh      = OW'(DATA_BYTES - 1) - end_idx;
        fs      = ONES << off;
        ls      = ONES >> sh;
        both    = fs & ls;
        if (beats == CW'(1)) begin
            fs = both;
            ls = both;
        end
        len_w  = 8'(beats - CW'(1));
        last_w = (CW'(rem_q) == bb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            rem_q       <= '0;
            bb_q        <= '0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            first_q     <= '0;
            last_strb_q <= '0;
            last_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= bus.req_addr;
                rem_q  <= bus.req_bytes;
            end
            if (state == CALC) begin
                bb_q        <= bb;
                cmd_addr_q  <= addr_q;
                cmd_len_q   <= len_w;
                first_q     <= fs;
                last_strb_q <= ls;
                last_q      <= last_w;
            end
            if (hs) begin
                addr_q <= addr_q + ADDR_W'(bb_q);
                rem_q  <= rem_q - LEN_W'(bb_q);
            end
        end
    end

    assign bus.req_ready      = (state == IDLE);
    assign bus.cmd_valid      = (state == ISSUE);
    assign bus.cmd_addr       = cmd_addr_q;
    assign bus.cmd_len        = cmd_len_q;
    assign bus.cmd_first_strb = first_q;
    assign bus.cmd_last_strb  = last_strb_q;
    assign bus.cmd_last       = last_q;
    assign busy               = (state != IDLE);
    assign done               = (state == FINISH);
endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Directed bench for axi_burst_scheduler: burst splitting, strobes,
// back-pressure, zero-length requests and asynchronous reset.
module tb_axi_burst_scheduler;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic done;
    int   errors = 0;
    int   checks = 0;

    axi_burst_scheduler_if #(.DATA_BYTES(8), .ADDR_W(32), .LEN_W(13)) bus ();

    axi_burst_scheduler #(
        .DATA_BYTES(8),
        .ADDR_W(32),
        .LEN_W(13),
        .MAX_BEATS(256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cmd(input string tag, input logic [31:0] a,
                              input logic [7:0] len, input logic [7:0] fs,
                              input logic [7:0] ls, input logic lst);
        chk({tag, ".valid"}, 64'(bus.cmd_valid), 64'(1));
        chk({tag, ".addr"}, 64'(bus.cmd_addr), 64'(a));
        chk({tag, ".len"}, 64'(bus.cmd_len), 64'(len));
        chk({tag, ".first"}, 64'(bus.cmd_first_strb), 64'(fs));
        chk({tag, ".laststrb"}, 64'(bus.cmd_last_strb), 64'(ls));
        chk({tag, ".last"}, 64'(bus.cmd_last), 64'(lst));
    endtask

    task automatic request(input logic [31:0] a, input logic [12:0] n);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_bytes = n;
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_bytes = '0;
        bus.cmd_ready = 1'b0;
        step();
        step();
        chk("rst.req_ready", 64'(bus.req_ready), 64'(1));
        chk("rst.cmd_valid", 64'(bus.cmd_valid), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.cmd_addr", 64'(bus.cmd_addr), 64'(0));
        chk("rst.cmd_len", 64'(bus.cmd_len), 64'(0));
        rst = 1'b0;
        step();

        // 4 KB crossing with back-pressure on the first command
        request(32'h0FF3, 13'd545);
        chk("t1.calc.valid", 64'(bus.cmd_valid), 64'(0));
        chk("t1.calc.busy", 64'(busy), 64'(1));
        chk("t1.calc.ready", 64'(bus.req_ready), 64'(0));
        step();
        expect_cmd("t1.c0", 32'h0FF3, 8'd1, 8'hF8, 8'hFF, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h4000;
        bus.req_bytes = 13'd16;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_cmd("t1.stall", 32'h0FF3, 8'd1, 8'hF8, 8'hFF, 1'b0);
            chk("t1.stall.req_ready", 64'(bus.req_ready), 64'(0));
        end
        bus.req_valid = 1'b0;
        bus.cmd_ready = 1'b1;
        step();
        chk("t1.gap.valid", 64'(bus.cmd_valid), 64'(0));
        step();
        expect_cmd("t1.c1", 32'h1000, 8'd66, 8'hFF, 8'h0F, 1'b1);
        step();
        chk("t1.done", 64'(done), 64'(1));
        chk("t1.done.valid", 64'(bus.cmd_valid), 64'(0));
        chk("t1.done.ready", 64'(bus.req_ready), 64'(0));
        step();
        chk("t1.idle.done", 64'(done), 64'(0));
        chk("t1.idle.ready", 64'(bus.req_ready), 64'(1));
        chk("t1.idle.busy", 64'(busy), 64'(0));

        // full 4 KB page split by the beat limit
        request(32'h0000, 13'd4096);
        step();
        expect_cmd("t2.c0", 32'h0000, 8'd255, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("t2.gap.valid", 64'(bus.cmd_valid), 64'(0));
        step();
        expect_cmd("t2.c1", 32'h0800, 8'd255, 8'hFF, 8'hFF, 1'b1);
        step();
        chk("t2.done", 64'(done), 64'(1));
        step();

        // sub-beat transfer inside one beat
        request(32'h0102, 13'd3);
        step();
        expect_cmd("t3.c0", 32'h0102, 8'd0, 8'h1C, 8'h1C, 1'b1);
        step();
        chk("t3.done", 64'(done), 64'(1));
        step();

        // address wrap past 2^32
        request(32'hFFFF_FFFC, 13'd8);
        step();
        expect_cmd("t4.c0", 32'hFFFF_FFFC, 8'd0, 8'hF0, 8'hF0, 1'b0);
        step();
        step();
        expect_cmd("t4.c1", 32'h0000_0000, 8'd0, 8'h0F, 8'h0F, 1'b1);
        step();
        chk("t4.done", 64'(done), 64'(1));
        step();

        // zero-length request
        request(32'h0200, 13'd0);
        chk("t5.done", 64'(done), 64'(1));
        chk("t5.valid", 64'(bus.cmd_valid), 64'(0));
        chk("t5.ready", 64'(bus.req_ready), 64'(0));
        step();
        chk("t5.idle.done", 64'(done), 64'(0));
        chk("t5.idle.ready", 64'(bus.req_ready), 64'(1));

        // asynchronous reset while a command is pending
        bus.cmd_ready = 1'b0;
        request(32'h0FF3, 13'd545);
        step();
        chk("t6.pre.valid", 64'(bus.cmd_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6.rst.valid", 64'(bus.cmd_valid), 64'(0));
        chk("t6.rst.busy", 64'(busy), 64'(0));
        chk("t6.rst.ready", 64'(bus.req_ready), 64'(1));
        chk("t6.rst.addr", 64'(bus.cmd_addr), 64'(0));
        chk("t6.rst.first", 64'(bus.cmd_first_strb), 64'(0));
        step();
        rst = 1'b0;
        step();
        chk("t6.post.ready", 64'(bus.req_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
